oe_mean_judge: RTL

OE_MEAN_JUDGE -- requirements
Module: oe_mean_judge

---
 rtl/oe_mean_judge.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/oe_mean_judge.sv
// ----------------------------------------------------------------------------
// oe_mean_judge
//   Turns the 90-pixel neighbour sum of a 91-pixel window into a window mean
//   and flags over-exposed centre pixels. A pixel is flagged when its centre is
//   at least OE_ABS and exceeds the mean by at least oe_th. Latency is 6 cycles
//   from sum90_en to out_vld, at one result per cycle.
//
//   Optional feature (macro OE_CNT_EN): a per-frame count of flagged pixels,
//   published on oe_cnt with a one-cycle cnt_done pulse at the end of each
//   frame. When the macro is undefined, oe_cnt and cnt_done are tied to 0.
//
// Ports
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   sum90_en      window valid, aligned with center_in
//   center_in     window centre pixel
//   sum90         neighbour sum, arrives 4 cycles after its sum90_en
//   oe_th         contrast threshold (quasi-static)
//   frame_start   pulse with the first valid window of a frame
//   frame_end     pulse with the last valid window of a frame
//   out_vld       result valid
//   mean_out      window mean (holds its value while out_vld is 0)
//   center_out    centre pixel aligned with mean_out (holds likewise)
//   oe_flag       over-exposure flag, 0 whenever out_vld is 0
//   oe_cnt        flagged-pixel count of the last completed frame
//   cnt_done      one-cycle pulse when oe_cnt updates
// ----------------------------------------------------------------------------
module oe_mean_judge #(
   parameter int unsigned DW_PART = 9,
   parameter int unsigned OE_ABS  = 448,
   parameter int unsigned CNT_W   = 22
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 sum90_en,
   input  logic [DW_PART-1:0]   center_in,
   input  logic [DW_PART+6:0]   sum90,
   input  logic [DW_PART-1:0]   oe_th,
   input  logic                 frame_start,
   input  logic                 frame_end,
   output logic                 out_vld,
   output logic [DW_PART-1:0]   mean_out,
   output logic [DW_PART-1:0]   center_out,
   output logic                 oe_flag,
   output logic [CNT_W-1:0]     oe_cnt,
   output logic                 cnt_done
);

   localparam int unsigned SW    = DW_PART + 7;   // sum90 width
   localparam int unsigned PW    = DW_PART + 17;  // product width
   localparam int unsigned MW    = DW_PART + 1;   // compare width, no wrap
   localparam int unsigned DLY   = 4;             // delay to meet sum90
   localparam int unsigned SHIFT = 16;
   // 729/65536 ~= 1/90; exact for every multiple of 90 up to 90*(2^DW_PART-1)
   localparam int unsigned RECIP = 729;

   // Delay line: valid and centre wait for the external summer
   logic [DLY-1:0]              r_en_d;
   logic [DLY-1:0][DW_PART-1:0] r_ctr_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_en_d  <= '0;
         r_ctr_d <= '0;
      end else begin
         r_en_d  <= {r_en_d[DLY-2:0], sum90_en};
         r_ctr_d <= {r_ctr_d[DLY-2:0], center_in};
      end
   end

   // Stage 1: reciprocal multiply
   logic [PW-1:0]      r_s1_prod;
   logic [DW_PART-1:0] r_s1_ctr;
   logic               r_s1_vld;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_prod <= '0;
         r_s1_ctr  <= '0;
         r_s1_vld  <= 1'b0;
      end else begin
         r_s1_prod <= PW'(sum90) * PW'(RECIP);
         r_s1_ctr  <= r_ctr_d[DLY-1];
         r_s1_vld  <= r_en_d[DLY-1];
      end
   end

   // Mean and over-exposure decision from stage-1 values
   logic [DW_PART-1:0] w_mean;
   logic [MW-1:0]      w_mean_th;
   logic               w_flag;

   always_comb begin
      w_mean    = DW_PART'(r_s1_prod >> SHIFT);
      w_mean_th = MW'(w_mean) + MW'(oe_th);
      w_flag    = r_s1_vld
                  && (MW'(r_s1_ctr) >= MW'(OE_ABS))
                  && (MW'(r_s1_ctr) >= w_mean_th);
   end

   // Stage 2: registered results; data outputs only move on a valid window
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_vld    <= 1'b0;
         oe_flag    <= 1'b0;
         mean_out   <= '0;
         center_out <= '0;
      end else begin
         out_vld <= r_s1_vld;
         oe_flag <= w_flag;
         if (r_s1_vld) begin
            mean_out   <= w_mean;
            center_out <= r_s1_ctr;
         end
      end
   end

`ifdef OE_CNT_EN
   // Frame markers follow the same path as sum90_en
   logic [DLY-1:0] r_fs_d;
   logic [DLY-1:0] r_fe_d;
   logic           r_s1_fs;
   logic           r_s1_fe;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fs_d  <= '0;
         r_fe_d  <= '0;
         r_s1_fs <= 1'b0;
         r_s1_fe <= 1'b0;
      end else begin
         r_fs_d  <= {r_fs_d[DLY-2:0], frame_start};
         r_fe_d  <= {r_fe_d[DLY-2:0], frame_end};
         r_s1_fs <= r_fs_d[DLY-1];
         r_s1_fe <= r_fe_d[DLY-1];
      end
   end

   // Running count; a frame start restarts it at this pixel's own flag
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [CNT_W-1:0] r_oe_cnt;
   logic             r_cnt_done;

   always_comb begin
      w_cnt_nxt = r_cnt;
      if (r_s1_fs) begin
         w_cnt_nxt = CNT_W'(w_flag);
      end else if (w_flag && (r_cnt != '1)) begin
         w_cnt_nxt = r_cnt + CNT_W'(1);
      end
   end

   // Frame end publishes the count including the final pixel
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt      <= '0;
         r_oe_cnt   <= '0;
         r_cnt_done <= 1'b0;
      end else begin
         r_cnt      <= w_cnt_nxt;
         r_cnt_done <= r_s1_fe;
         if (r_s1_fe) begin
            r_oe_cnt <= w_cnt_nxt;
         end
      end
   end

   assign oe_cnt   = r_oe_cnt;
   assign cnt_done = r_cnt_done;
`else
   // Frame markers are only meaningful to the counter
   logic w_unused_frame;
   assign w_unused_frame = frame_start ^ frame_end;

   assign oe_cnt   = '0;
   assign cnt_done = 1'b0;
`endif

endmodule
